// File: rtl/fractal_sync_arbiter.sv
// Round-robin arbiter sharing one fractal-sync master port between N_REQ local
// requesters: captures sync pulses, issues sync, waits for wake/error/timeout, returns the result.
module fractal_sync_arbiter #(
  parameter int N_REQ      = 2,
  parameter int LVL_W      = 5,
  parameter int TIMEOUT_W  = 16,
  parameter int TIMEOUT_EN = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles_i,
  input  logic [N_REQ-1:0]       req_sync_i,
  input  logic [N_REQ*LVL_W-1:0] req_level_i,
  output logic [N_REQ-1:0]       req_wake_o,
  output logic [N_REQ-1:0]       req_error_o,
  output logic                   sync_o,
  output logic [LVL_W-1:0]       level_o,
  input  logic                   wake_i,
  input  logic                   error_i,
  output logic                   ack_o,
  output logic                   busy_o,
  output logic [N_REQ-1:0]       overflow_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t                        state, state_nxt;
  logic [N_REQ-1:0]              pending;
  logic [N_REQ-1:0][LVL_W-1:0]   level_q;
  logic [IDX_W-1:0]              grant_idx, rr_ptr, pick_idx, scan_idx;
  logic                          pick_vld;
  logic [TIMEOUT_W-1:0]          tmo_cnt;
  logic [N_REQ-1:0]              grant_oh, clr_mask;
  logic                          tmo_hit, done;

  // First pending slot at or after the RR pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!pick_vld && pending[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  assign tmo_hit  = (TIMEOUT_EN != 0) && (timeout_cycles_i != '0) &&
                    (tmo_cnt == timeout_cycles_i - TIMEOUT_W'(1));
  assign done     = (state == S_ACK) || (state == S_ERR);
  assign clr_mask = done ? grant_oh : '0;

  always_comb begin
    state_nxt   = state;
    sync_o      = 1'b0;
    level_o     = '0;
    ack_o       = 1'b0;
    req_wake_o  = '0;
    req_error_o = '0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
      S_ISSUE: begin
        sync_o    = 1'b1;
        level_o   = level_q[grant_idx];
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (error_i)      state_nxt = S_ERR;
        else if (wake_i)  state_nxt = S_ACK;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      S_ACK: begin
        ack_o      = 1'b1;
        req_wake_o = grant_oh;
        state_nxt  = S_IDLE;
      end
      S_ERR: begin
        ack_o       = 1'b1;
        req_error_o = grant_oh;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state      <= S_IDLE;
      pending    <= '0;
      level_q    <= '0;
      overflow_o <= '0;
      tmo_cnt    <= '0;
      rr_ptr     <= '0;
      grant_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && pick_vld) grant_idx <= pick_idx;
      if (done) rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (state == S_ISSUE)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      // A new pulse on a slot being released re-arms it instead of overflowing.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_sync_i[i] && (!pending[i] || clr_mask[i])) begin
          pending[i] <= 1'b1;
          level_q[i] <= req_level_i[i*LVL_W +: LVL_W];
        end else if (req_sync_i[i]) begin
          overflow_o[i] <= 1'b1;
        end else if (clr_mask[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/fractal_sync_arbiter.md
Name: fractal_sync_arbiter

Overview:
- Shares one fractal-sync master port between N_REQ local requesters, such as the core's Xif sync decoder and the DMA/accelerator sync sources in the tile.
- Latches one-cycle sync pulses from each requester into a pending slot.
- Grants pending slots round-robin and runs the downstream sync → wait-for-wake → ack sequence for the granted slot.
- Returns wake or error to the granted requester and supervises the wait with an optional timeout.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- LVL_W, 5, width of the synchronization level field.
- TIMEOUT_W, 16, width of the wait-timeout counter.
- TIMEOUT_EN, 1, 1 = enable the wake timeout; 0 = wait indefinitely.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- timeout_cycles_i  in  TIMEOUT_W  wait limit; a value of 0 disables the timeout.
- req_sync_i  in  N_REQ  per-requester one-cycle sync request pulse.
- req_level_i  in  N_REQ*LVL_W  per-requester level; sampled with req_sync_i.
- req_wake_o  out  N_REQ  one-cycle wake pulse to the granted requester.
- req_error_o  out  N_REQ  one-cycle error pulse to the granted requester.
- sync_o  out  1  downstream sync strobe.
- level_o  out  LVL_W  downstream level; valid only while sync_o=1.
- wake_i  in  1  downstream wake.
- error_i  in  1  downstream error.
- ack_o  out  1  downstream wake acknowledge.
- busy_o  out  1  high when the FSM is not in IDLE.
- overflow_o  out  N_REQ  sticky per-requester dropped-request flag.

Behaviour:
- Reset and clear are synchronous, active-high, and take effect on a clk_i edge. Both have identical effect:
  - FSM goes to IDLE; pending, stored levels, overflow_o and the timeout counter clear; RR pointer = 0.
  - All outputs are 0.
  - Reset in any state aborts the sequence. No wake, error or ack is emitted for the aborted request, and no later pulse for it is emitted either.
- Capture:
  - req_sync_i[i]=1 with pending[i]=0 → next cycle pending[i]=1 and level[i]=req_level_i slice i.
  - req_sync_i[i]=1 with pending[i]=1, and slot i not being cleared this cycle → request dropped, stored level unchanged, overflow_o[i] set (sticky until reset/clear).
  - Capture on a slot being cleared in the same cycle (ACK/ERR of slot i) → the set wins. pending[i] stays 1 with the new level; no overflow.
- Arbitration:
  - In IDLE with any pending bit set, grant the first pending index at or after the RR pointer, scanning upward and wrapping.
  - Grant is registered as grant_idx; next state is ISSUE.
  - A request captured in the same cycle the arbiter is in IDLE is not visible until the next cycle, so minimum latency is pulse → sync_o = 2 cycles.
- FSM states:
  - IDLE: outputs low. Go to ISSUE when any pending bit is set.
  - ISSUE: sync_o=1 and level_o=level[grant_idx] for exactly 1 cycle. Load the timeout counter to 0. Go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - error_i=1 → ERR. error_i has priority over wake_i when both are high in the same cycle.
    - else wake_i=1 → ACK.
    - else TIMEOUT_EN=1, timeout_cycles_i≠0 and counter == timeout_cycles_i−1 → ERR, i.e. ERR is entered on the timeout_cycles_i-th WAIT cycle.
  - ACK: ack_o=1, req_wake_o[grant_idx]=1, clear pending[grant_idx], RR pointer = grant_idx+1 mod N_REQ. Go to IDLE.
  - ERR: ack_o=1 (releases downstream), req_error_o[grant_idx]=1, clear pending[grant_idx], advance the RR pointer as in ACK. Go to IDLE.
- Outputs and downstream rules:
  - busy_o = (state≠IDLE).
  - At most one bit of req_wake_o | req_error_o is high in any cycle.
  - wake_i/error_i are ignored outside WAIT.
  - A wake_i arriving in ISSUE is ignored; the downstream protocol guarantees wake comes no earlier than one cycle after sync.
  - Back-to-back service: IDLE costs 1 cycle between grants, so the sequence per grant is ISSUE, WAIT ≥1 cycle, ACK/ERR, IDLE.

Test Plan:
- Single request, level: req_sync_i=01, level=3 at cycle 0. Required: sync_o=1 with level_o=3 at cycle 2. With wake_i at cycle 5: ack_o=1 and req_wake_o=01 at cycle 6, busy_o=0 at cycle 7.
- Contention and RR (N_REQ=2): both requesters pulse at cycle 0 with levels 1 and 2. Required: level_o=1 is served first. After its wake, level_o=2 is issued, with sync_o at exactly 2 cycles after ACK. The RR pointer ends at 0.
- Fairness and wrap: requester 1 re-requests immediately after each wake while requester 0 stays pending. Required: grants alternate 1,0,1,0; requester 1 is never granted twice consecutively.
- Overflow and same-cycle capture:
  - Second pulse from requester 0 while it is in WAIT → overflow_o=01 and the first level is kept.
  - Pulse in the ACK cycle of requester 0 → a new grant follows and overflow_o is unchanged.
- Timeout and error priority, timeout_cycles_i=4, no wake: ERR is entered on the 4th WAIT cycle with req_error_o=01 and ack_o=1. Separately, wake_i and error_i both high in WAIT → error path only.
- Reset mid-operation: assert rst_i for 1 cycle during WAIT. Required: all outputs 0 the following cycle, pending cleared, and a later wake_i produces no req_wake_o.
